// File: rtl/uart_packet_rx.sv
// Purpose: frames 6-byte position/click packets from a UART byte stream, checks the XOR sum, commits atomically.
// Latency: outputs and frame_valid update 1 clk after the checksum byte strobe; errors also pulse 1 clk after.
// Backpressure: none; every rx_valid byte is consumed, and stalled packets are dropped on inter-byte gap timeout.
//
// Ports:
//   clk         pixel clock, the only clock
//   rst         asynchronous active-low reset
//   rx_data     received byte, qualified by rx_valid
//   rx_valid    single-cycle byte strobe
//   pl2_posx    remote player X (12b), changes only on commit
//   pl2_posy    remote player Y (12b), changes only on commit
//   pl2_click   remote mouse-left state, changes only on commit
//   frame_valid one-cycle pulse on a committed packet
//   chk_err     one-cycle pulse on checksum mismatch
//   gap_err     one-cycle pulse when a packet is abandoned on gap timeout
//   link_up     high while good packets keep arriving within LINK_CYCLES
//   err_count   saturating count of chk_err + gap_err events
module uart_packet_rx #(
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter int          GAP_CYCLES  = 65000,
   parameter int          LINK_CYCLES = 6500000,
   parameter logic [11:0] RST_POSX    = 12'd974,
   parameter logic [11:0] RST_POSY    = 12'd679
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [11:0] pl2_posx,
   output logic [11:0] pl2_posy,
   output logic        pl2_click,
   output logic        frame_valid,
   output logic        chk_err,
   output logic        gap_err,
   output logic        link_up,
   output logic [7:0]  err_count
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int LW = $clog2(LINK_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [LW-1:0] LINK_MAX = LW'(LINK_CYCLES);

   localparam logic [1:0] S_HUNT    = 2'd0;
   localparam logic [1:0] S_PAYLOAD = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [7:0]    sum_q, sum_d;
   // Shadow copy of B1..B3 plus the click bit of B4; only bit 0 of B4 carries data.
   logic [7:0]    shb0_q, shb0_d;
   logic [7:0]    shb1_q, shb1_d;
   logic [7:0]    shb2_q, shb2_d;
   logic          shclk_q, shclk_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [LW-1:0] link_cnt_q, link_cnt_d;
   logic [11:0]   posx_q, posx_d;
   logic [11:0]   posy_q, posy_d;
   logic          click_q, click_d;
   logic          frame_valid_q, frame_valid_d;
   logic          chk_err_q, chk_err_d;
   logic          gap_err_q, gap_err_d;
   logic          link_up_q, link_up_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          gap_expire;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      sum_d         = sum_q;
      shb0_d        = shb0_q;
      shb1_d        = shb1_q;
      shb2_d        = shb2_q;
      shclk_d       = shclk_q;
      gap_d         = gap_q;
      link_cnt_d    = link_cnt_q;
      posx_d        = posx_q;
      posy_d        = posy_q;
      click_d       = click_q;
      frame_valid_d = 1'b0;
      chk_err_d     = 1'b0;
      gap_err_d     = 1'b0;
      link_up_d     = link_up_q;
      err_cnt_d     = err_cnt_q;

      // A byte landing on the expiry cycle wins, so expiry requires an idle cycle.
      gap_expire = (state_q != S_HUNT) && !rx_valid && (gap_q == GAP_LAST);

      case (state_q)
         S_HUNT: begin
            if (rx_valid && rx_data == HEADER) begin
               state_d = S_PAYLOAD;
               idx_d   = 2'd0;
               sum_d   = 8'h00;
            end
         end
         S_PAYLOAD: begin
            // HEADER-valued bytes are plain data here: no resync mid-packet.
            if (rx_valid) begin
               case (idx_q)
                  2'd0:    shb0_d  = rx_data;
                  2'd1:    shb1_d  = rx_data;
                  2'd2:    shb2_d  = rx_data;
                  default: shclk_d = rx_data[0];
               endcase
               sum_d = sum_q ^ rx_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (rx_valid) begin
               if (rx_data == sum_q) begin
                  posx_d        = {shb0_q, shb1_q[7:4]};
                  posy_d        = {shb1_q[3:0], shb2_q};
                  click_d       = shclk_q;
                  frame_valid_d = 1'b1;
               end else begin
                  chk_err_d = 1'b1;
               end
               state_d = S_HUNT;
            end
         end
         default: state_d = S_HUNT;
      endcase

      if (gap_expire) begin
         state_d   = S_HUNT;
         gap_err_d = 1'b1;
      end

      if (state_q == S_HUNT || rx_valid || gap_expire) begin
         gap_d = '0;
      end else begin
         gap_d = gap_q + GW'(1);
      end

      if (frame_valid_d) begin
         link_cnt_d = '0;
         link_up_d  = 1'b1;
      end else begin
         if (link_cnt_q != LINK_MAX) begin
            link_cnt_d = link_cnt_q + LW'(1);
         end
         if (link_cnt_d == LINK_MAX) begin
            link_up_d = 1'b0;
         end
      end

      if ((chk_err_d || gap_err_d) && err_cnt_q != 8'hFF) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_HUNT;
         idx_q         <= 2'd0;
         sum_q         <= 8'h00;
         shb0_q        <= 8'h00;
         shb1_q        <= 8'h00;
         shb2_q        <= 8'h00;
         shclk_q       <= 1'b0;
         gap_q         <= '0;
         link_cnt_q    <= '0;
         posx_q        <= RST_POSX;
         posy_q        <= RST_POSY;
         click_q       <= 1'b0;
         frame_valid_q <= 1'b0;
         chk_err_q     <= 1'b0;
         gap_err_q     <= 1'b0;
         link_up_q     <= 1'b0;
         err_cnt_q     <= 8'h00;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         sum_q         <= sum_d;
         shb0_q        <= shb0_d;
         shb1_q        <= shb1_d;
         shb2_q        <= shb2_d;
         shclk_q       <= shclk_d;
         gap_q         <= gap_d;
         link_cnt_q    <= link_cnt_d;
         posx_q        <= posx_d;
         posy_q        <= posy_d;
         click_q       <= click_d;
         frame_valid_q <= frame_valid_d;
         chk_err_q     <= chk_err_d;
         gap_err_q     <= gap_err_d;
         link_up_q     <= link_up_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign pl2_posx    = posx_q;
   assign pl2_posy    = posy_q;
   assign pl2_click   = click_q;
   assign frame_valid = frame_valid_q;
   assign chk_err     = chk_err_q;
   assign gap_err     = gap_err_q;
   assign link_up     = link_up_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Purpose: self-checking bench for uart_packet_rx; packet-level queue model compared every cycle plus literal checks.
// Latency: expects commits and error pulses 1 clk after the closing byte strobe.
// Backpressure: none; bytes are strobed one per chosen spacing, never stalled.
module tb_uart_packet_rx;

   localparam int          GAP  = 200;
   localparam int          LINK = 1000;
   localparam logic [7:0]  HDR  = 8'hA5;
   localparam logic [11:0] RPX  = 12'd974;
   localparam logic [11:0] RPY  = 12'd679;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [11:0] pl2_posx, pl2_posy;
   logic        pl2_click, frame_valid, chk_err, gap_err, link_up;
   logic [7:0]  err_count;

   int n_cmp = 0;
   int n_bad = 0;

   uart_packet_rx #(
      .HEADER(HDR), .GAP_CYCLES(GAP), .LINK_CYCLES(LINK), .RST_POSX(RPX), .RST_POSY(RPY)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .pl2_posx(pl2_posx), .pl2_posy(pl2_posy), .pl2_click(pl2_click),
      .frame_valid(frame_valid), .chk_err(chk_err), .gap_err(gap_err),
      .link_up(link_up), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packet-level model: collect bytes after a header, judge at six bytes, drop after GAP idle edges.
   logic [11:0] m_posx = RPX;
   logic [11:0] m_posy = RPY;
   logic        m_click = 1'b0;
   logic        m_fv = 1'b0, m_ce = 1'b0, m_ge = 1'b0, m_link = 1'b0;
   int          m_err = 0;
   int          m_idle = 0;
   int          m_since = 0;
   bit          m_ever = 1'b0;
   logic [7:0]  pkt[$];
   logic [7:0]  x;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_posx = RPX; m_posy = RPY; m_click = 1'b0;
         m_fv = 1'b0; m_ce = 1'b0; m_ge = 1'b0; m_link = 1'b0;
         m_err = 0; m_idle = 0; m_since = 0; m_ever = 1'b0;
         pkt.delete();
      end else begin
         m_fv = 1'b0; m_ce = 1'b0; m_ge = 1'b0;
         if (rx_valid) begin
            m_idle = 0;
            if (pkt.size() != 0 || rx_data == HDR) pkt.push_back(rx_data);
            if (pkt.size() == 6) begin
               x = pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4];
               if (x == pkt[5]) begin
                  m_posx  = {pkt[1], pkt[2][7:4]};
                  m_posy  = {pkt[2][3:0], pkt[3]};
                  m_click = pkt[4][0];
                  m_fv    = 1'b1;
               end else begin
                  m_ce = 1'b1;
               end
               pkt.delete();
            end
         end else if (pkt.size() != 0) begin
            m_idle++;
            if (m_idle == GAP) begin
               m_ge = 1'b1;
               m_idle = 0;
               pkt.delete();
            end
         end
         if (m_fv) begin
            m_since = 0;
            m_ever  = 1'b1;
         end else if (m_since < LINK) begin
            m_since++;
         end
         m_link = m_ever && (m_since < LINK);
         if ((m_ce || m_ge) && m_err < 255) m_err++;
      end
   end

   always @(negedge clk) begin
      chk("posx",  32'(pl2_posx),    32'(m_posx));
      chk("posy",  32'(pl2_posy),    32'(m_posy));
      chk("click", 32'(pl2_click),   32'(m_click));
      chk("fv",    32'(frame_valid), 32'(m_fv));
      chk("cerr",  32'(chk_err),     32'(m_ce));
      chk("gerr",  32'(gap_err),     32'(m_ge));
      chk("link",  32'(link_up),     32'(m_link));
      chk("ecnt",  32'(err_count),   32'(m_err));
   end

   // All drivers are called at a negedge; the strobe is sampled at the following posedge.
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [47:0] p, input int spacing);
      for (int i = 0; i < 6; i++) begin
         send_byte(p[47-8*i -: 8]);
         if (i < 5) idle(spacing - 1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
   endtask

   localparam logic [47:0] GOOD = 48'hA5_3C_D2_A7_01_48;
   localparam logic [47:0] BAD  = 48'hA5_3C_D2_A7_01_49;
   localparam logic [47:0] HDRP = 48'hA5_A5_00_00_00_A5;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      idle(3);
      chk("rst_posx", 32'(pl2_posx), 32'd974);
      chk("rst_posy", 32'(pl2_posy), 32'd679);
      chk("rst_link", 32'(link_up), 32'd0);
      chk("rst_ecnt", 32'(err_count), 32'd0);
      rst = 1'b1;
      idle(2);

      // Good packet, 16-cycle spacing
      for (int i = 0; i < 5; i++) begin
         send_byte(GOOD[47-8*i -: 8]);
         idle(15);
      end
      chk("pre_fv", 32'(frame_valid), 32'd0);
      chk("pre_link", 32'(link_up), 32'd0);
      send_byte(8'h48);
      chk("t1_fv", 32'(frame_valid), 32'd1);
      chk("t1_link", 32'(link_up), 32'd1);
      chk("t1_posx", 32'(pl2_posx), 32'h3CD);
      chk("t1_posy", 32'(pl2_posy), 32'h2A7);
      chk("t1_click", 32'(pl2_click), 32'd1);
      idle(1);
      chk("t1_fv_off", 32'(frame_valid), 32'd0);

      // Bad checksum from reset
      do_reset();
      send_pkt(BAD, 16);
      chk("t2_cerr", 32'(chk_err), 32'd1);
      chk("t2_posx", 32'(pl2_posx), 32'd974);
      chk("t2_posy", 32'(pl2_posy), 32'd679);
      chk("t2_ecnt", 32'(err_count), 32'd1);
      chk("t2_link", 32'(link_up), 32'd0);
      idle(1);
      chk("t2_cerr_off", 32'(chk_err), 32'd0);
      send_pkt(GOOD, 16);
      chk("t2_fv", 32'(frame_valid), 32'd1);
      idle(3);

      // Garbage then packet with HEADER-valued payload
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
      idle(4);
      send_pkt(HDRP, 3);
      chk("t3_fv", 32'(frame_valid), 32'd1);
      chk("t3_posx", 32'(pl2_posx), 32'hA50);
      chk("t3_posy", 32'(pl2_posy), 32'h000);
      chk("t3_click", 32'(pl2_click), 32'd0);
      idle(3);

      // Gap timeout
      send_byte(8'hA5); idle(15); send_byte(8'h3C);
      idle(GAP - 1);
      chk("t4_gerr_early", 32'(gap_err), 32'd0);
      idle(1);
      chk("t4_gerr", 32'(gap_err), 32'd1);
      chk("t4_ecnt", 32'(err_count), 32'd2);
      idle(1);
      send_pkt(GOOD, 16);
      chk("t4_fv", 32'(frame_valid), 32'd1);
      idle(2);

      // Byte arriving on the expiry edge keeps the packet alive
      send_byte(8'hA5); idle(15); send_byte(8'h3C);
      idle(GAP - 1);
      send_byte(8'hD2);
      chk("t5_nogerr", 32'(gap_err), 32'd0);
      idle(15); send_byte(8'hA7); idle(15); send_byte(8'h01); idle(15);
      send_byte(8'h48);
      chk("t5_fv", 32'(frame_valid), 32'd1);

      // Link timeout
      idle(LINK - 1);
      chk("t6_link_hi", 32'(link_up), 32'd1);
      idle(1);
      chk("t6_link_lo", 32'(link_up), 32'd0);
      chk("t6_posx", 32'(pl2_posx), 32'h3CD);
      send_pkt(HDRP, 2);
      chk("t6_link_back", 32'(link_up), 32'd1);
      idle(2);

      // err_count saturation
      for (int i = 0; i < 300; i++) send_pkt(BAD, 1);
      idle(1);
      chk("t7_ecnt", 32'(err_count), 32'd255);

      // Asynchronous reset mid-packet
      send_byte(8'hA5); send_byte(8'h3C);
      #3 rst = 1'b0;
      #1;
      chk("t8_posx", 32'(pl2_posx), 32'd974);
      chk("t8_posy", 32'(pl2_posy), 32'd679);
      chk("t8_click", 32'(pl2_click), 32'd0);
      chk("t8_link", 32'(link_up), 32'd0);
      chk("t8_ecnt", 32'(err_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(1);
      send_byte(8'hD2); send_byte(8'hA7); send_byte(8'h01); send_byte(8'h48);
      chk("t8_nofv", 32'(frame_valid), 32'd0);
      chk("t8_held", 32'(pl2_posx), 32'd974);
      idle(2);
      send_pkt(GOOD, 4);
      chk("t8_fv", 32'(frame_valid), 32'd1);
      chk("t8_posx2", 32'(pl2_posx), 32'h3CD);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
- Receive-side framer for the inter-board link. It consumes bytes from the UART receiver and hunts for a fixed header byte.
- It assembles a 6-byte packet carrying the remote player's position and click state, and checks an XOR checksum.
- Good packets are committed atomically to registered outputs that drive Player_2 drawing and ball collision control.
- It also tracks inter-byte gaps and link liveness, so a dead or desynchronised link is detected and reported.

Parameters:
- HEADER, 8'hA5, start-of-packet byte.
- GAP_CYCLES, 65000, maximum clk cycles allowed between consecutive bytes of one packet (1 ms at 65 MHz).
- LINK_CYCLES, 6500000, clk cycles without a good packet before link_up drops (100 ms).
- RST_POSX, 12'd974, remote X position held after reset.
- RST_POSY, 12'd679, remote Y position held after reset.

Ports:
- clk  in  1  pixel clock (65 MHz); the only clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe; rx_data is valid in this cycle.
- pl2_posx  out  12  remote player X, registered.
- pl2_posy  out  12  remote player Y, registered.
- pl2_click  out  1  remote mouse-left state, registered.
- frame_valid  out  1  one-cycle pulse when a good packet is committed.
- chk_err  out  1  one-cycle pulse when the checksum mismatches.
- gap_err  out  1  one-cycle pulse when a packet is abandoned on gap timeout.
- link_up  out  1  high while good packets keep arriving within LINK_CYCLES.
- err_count  out  8  saturating count of chk_err plus gap_err events.

Behaviour:
- Packet format:
  - B0 = HEADER
  - B1 = posx[11:4]
  - B2 = {posx[3:0], posy[11:8]}
  - B3 = posy[7:0]
  - B4 = {7'b0, click}
  - B5 = B1^B2^B3^B4
- Reset (rst=0, asynchronous):
  - pl2_posx=RST_POSX, pl2_posy=RST_POSY, pl2_click=0.
  - frame_valid=chk_err=gap_err=0, link_up=0, err_count=0.
  - FSM goes to HUNT; byte index=0, gap counter=0, link counter=0, shadow registers=0.
- FSM states:
  - HUNT:
    - rx_valid with rx_data==HEADER -> PAYLOAD, index=0, running XOR=0.
    - Any other byte is discarded silently (no error).
  - PAYLOAD:
    - Each rx_valid stores the byte into shadow[index] and XORs it into the running sum; index increments.
    - The byte arriving at index 3 -> CHECK.
    - A byte equal to HEADER is treated as data; there is no resync inside a packet.
  - CHECK:
    - If rx_valid and rx_data==running XOR, commit: outputs load from the shadow registers on the next clock edge and frame_valid pulses in that same cycle. Latency is 1 cycle after the B5 strobe. Then -> HUNT.
    - If rx_valid and the checksum mismatches: chk_err pulses (1 cycle after B5), outputs are unchanged, -> HUNT.
- Gap timer:
  - Counts in PAYLOAD and CHECK, and clears on every rx_valid.
  - When it reaches GAP_CYCLES-1 with no rx_valid in that cycle: gap_err pulses next cycle, FSM -> HUNT, shadow data discarded.
  - Simultaneous rx_valid and expiry: the byte wins and the timer clears.
  - The timer is held at 0 in HUNT.
- Link:
  - The link counter increments each cycle, saturating at LINK_CYCLES.
  - It clears on commit.
  - link_up=1 in the cycle after a commit; link_up=0 once the counter reaches LINK_CYCLES.
  - Position outputs hold their last committed values while the link is down; no auto-reset to defaults.
- err_count: +1 per chk_err or gap_err and saturates at 255. Both errors cannot occur in the same cycle.
- Outputs never change except on commit or reset, so pl2_posx, pl2_posy and pl2_click always come from the same packet (no tearing).
- No width checks are applied to the received coordinates. Range limiting is done downstream.
- Reset asserted mid-packet aborts the packet immediately; the next packet requires a fresh HEADER.

Test Plan:
- Reset, then the good packet A5,3C,D2,A7,01,chk=3C^D2^A7^01=48 with strobes 16 cycles apart:
  - pl2_posx=12'h3CD, pl2_posy=12'h2A7, pl2_click=1.
  - frame_valid pulses exactly 1 cycle after the B5 strobe.
  - link_up rises in the same cycle.
- The same packet with B5=49 -> chk_err single pulse, outputs stay 974/679, err_count=1, link_up stays 0. The next good packet commits normally.
- Garbage bytes 00,FF,12, then a good packet whose payload contains A5 (A5,A5,00,00,00,A5) -> commits posx=12'hA50, posy=12'h000, click=0. The in-packet A5 is not treated as a header.
- A5,3C, then silence for GAP_CYCLES -> gap_err pulse, no commit, FSM back in HUNT. A following good packet commits.
- Good packet, then no traffic for LINK_CYCLES (shorten the parameter to 1000 in the bench) -> link_up falls at cycle 1000 and positions are held. Another good packet -> link_up returns high.
- 300 bad-checksum packets -> err_count saturates at 255. Assert rst mid-packet -> all outputs return to reset values asynchronously.
